// File: rtl/col_to_row_buffer.sv
// Double-buffered NxN transpose: columns are written into one bank while the
// other bank is read out row by row. Two banks give full throughput when streaming.
module col_to_row_buffer #(
  parameter int W = 12,
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*W-1:0]            in_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*W-1:0]            out_row,
  output logic                      out_last,
  output logic [2*$clog2(N)+3:0]    dbg_state
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Valid/ready: a transfer happens on a rising clk edge where valid and ready
  // are both high. Neither valid nor ready depends combinationally on the
  // other side, and once out_valid rises, out_row holds until its transfer.

  logic [W-1:0]  mem [2][N][N];   // [bank][row][col]
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_col;
  logic [AW-1:0] rd_row;
  logic          wr_fire;
  logic          rd_fire;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_row == LAST);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Layout: {full[1], full[0], wr_bank, rd_bank, wr_col, rd_row}
  assign dbg_state = {full, wr_bank, rd_bank, wr_col, rd_row};

  // Storage carries no reset; the full flags alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < N; i++) begin
        mem[wr_bank][i][wr_col] <= in_col[i*W +: W];
      end
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) begin
      out_row[j*W +: W] = mem[rd_bank][rd_row][j];
    end
  end

  // The write side only ever targets an empty bank and the read side a full
  // one, so a same-cycle set and clear always touch different flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= '0;
      rd_row  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_col == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_col        <= '0;
          wr_bank       <= !wr_bank;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_row == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_row        <= '0;
          rd_bank       <= !rd_bank;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_col_to_row_buffer.sv
// Directed and randomized checks of col_to_row_buffer: latency, streaming,
// back-pressure, async reset, and transpose correctness over many blocks.
module tb_col_to_row_buffer;

  localparam int W = 12;
  localparam int N = 8;
  localparam int LIMIT = 20000;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_col;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_row;
  logic           out_last;
  logic [9:0]     dbg_state;

  int vectors;
  int miscompares;

  logic [N*W-1:0] exp_q[$];
  logic [W-1:0]   rbase;
  int             rows_seen;
  int             rcyc;
  int             scyc;
  logic           accepted;
  logic           prev_stall;
  logic [N*W-1:0] prev_row;
  logic [N*W-1:0] exp_row;

  col_to_row_buffer #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] col_of(input logic [W-1:0] base, input int c);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(16 * i + c);
    return v;
  endfunction

  function automatic logic [N*W-1:0] row_of(input logic [W-1:0] base, input int r);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = base + W'(16 * r + j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_col = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_dbg", dbg_state, 10'd0);
    rst = 1'b1;
  endtask

  // driver: one block of columns, one per cycle
  task automatic feed_block(input logic [W-1:0] base, input logic exp_ov);
    for (int c = 0; c < N; c++) begin
      in_valid = 1'b1;
      in_col = col_of(base, c);
      #1;
      chk("feed_in_ready", in_ready, 1'b1);
      chk("feed_out_valid", out_valid, exp_ov);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_rows(input logic [W-1:0] base);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      #1;
      chk("rows_valid", out_valid, 1'b1);
      chk("rows_data", out_row, row_of(base, r));
      chk("rows_last", out_last, r == N - 1);
      tick();
    end
    #1;
    chk("rows_drained", out_valid, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // single block, latency of one cycle after the last column
    apply_reset();
    out_ready = 1'b1;
    feed_block(12'h000, 1'b0);
    expect_rows(12'h000);

    // three back-to-back blocks at full rate
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = (k < 24);
      in_col = col_of(W'(256 * (k / 8)), k % 8);
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      if (k < 8) begin
        chk("stream_idle", out_valid, 1'b0);
      end else begin
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_row", out_row, row_of(W'(256 * ((k - 8) / 8)), (k - 8) % 8));
        chk("stream_last", out_last, ((k - 8) % 8) == 7);
      end
      if (k == 16) chk("stream_swap_dbg", dbg_state, 10'b10_0_1_000_000);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("stream_drained", out_valid, 1'b0);

    // back-pressure: both banks fill, source holds column 0 of block 2
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_col = col_of(W'(256 * (k / 8)), k % 8);
      #1;
      chk("bp_fill_ready", in_ready, 1'b1);
      tick();
    end
    for (int k = 16; k < 18; k++) begin
      in_col = col_of(12'h200, 0);
      #1;
      chk("bp_full_ready", in_ready, 1'b0);
      chk("bp_full_valid", out_valid, 1'b1);
      chk("bp_hold_row", out_row, row_of(12'h000, 0));
      tick();
    end
    for (int k = 18; k < 26; k++) begin
      out_ready = 1'b1;
      #1;
      chk("bp_drain_ready", in_ready, 1'b0);
      chk("bp_drain_row", out_row, row_of(12'h000, k - 18));
      chk("bp_drain_last", out_last, k == 25);
      tick();
    end
    for (int k = 26; k < 34; k++) begin
      in_col = col_of(12'h200, k - 26);
      #1;
      chk("bp_resume_ready", in_ready, 1'b1);
      chk("bp_bank1_row", out_row, row_of(12'h100, k - 26));
      if (k == 27) chk("bp_bank0_dbg", dbg_state, 10'b10_0_1_001_001);
      tick();
    end
    expect_rows(12'h200);

    // async reset mid-block and with both banks full
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_col = col_of(12'h500, c);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("rst5_dbg_before", dbg_state, 10'b00_0_0_101_000);
    #1;
    rst = 1'b0;
    #1;
    chk("rst5_in_ready", in_ready, 1'b1);
    chk("rst5_out_valid", out_valid, 1'b0);
    chk("rst5_dbg", dbg_state, 10'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_col = col_of(W'(12'h600 + 256 * (k / 8)), k % 8);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("rstf_before_ready", in_ready, 1'b0);
    chk("rstf_before_valid", out_valid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstf_in_ready", in_ready, 1'b1);
    chk("rstf_out_valid", out_valid, 1'b0);
    chk("rstf_out_last", out_last, 1'b0);
    chk("rstf_dbg", dbg_state, 10'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    feed_block(12'h7a0, 1'b0);
    expect_rows(12'h7a0);

    // random handshakes over 100 blocks, scoreboarded
    apply_reset();
    rows_seen = 0;
    rcyc = 0;
    scyc = 0;
    prev_stall = 1'b0;
    prev_row = '0;
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          rbase = W'($urandom_range(0, 4095));
          for (int r = 0; r < N; r++) exp_q.push_back(row_of(rbase, r));
          for (int c = 0; c < N; c++) begin
            accepted = 1'b0;
            while (!accepted && scyc < LIMIT) begin
              in_valid = ($urandom_range(0, 1) == 1);
              in_col = col_of(rbase, c);
              #1;
              accepted = in_valid && in_ready;
              tick();
              scyc++;
            end
          end
        end
        in_valid = 1'b0;
      end
      begin
        while (rows_seen < 100 * N && rcyc < LIMIT) begin
          out_ready = ($urandom_range(0, 1) == 1);
          #1;
          if (prev_stall) begin
            chk("rand_hold_valid", out_valid, 1'b1);
            chk("rand_hold_row", out_row, prev_row);
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_extra_row", 1'b1, 1'b0);
            end else begin
              exp_row = exp_q.pop_front();
              chk("rand_row", out_row, exp_row);
              chk("rand_last", out_last, (rows_seen % N) == N - 1);
            end
            rows_seen++;
          end
          prev_stall = out_valid && !out_ready;
          prev_row = out_row;
          tick();
          rcyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("rand_row_count", rows_seen, 100 * N);
    chk("rand_queue_empty", exp_q.size(), 0);
    #1;
    chk("rand_drained", out_valid, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/col_to_row_buffer.md
Name: col_to_row_buffer

Overview:
- Double-buffered 8x8 transpose stage for the JPEG datapath, mirroring the row-in/column-out transpose memory.
- Accepts an 8x8 block of 12-bit coefficients one column per transfer and emits the same block one row per transfer.
- Two banks allow one block to be written while the previous block is read.
- Sits between the 1-D column DCT/IDCT stage and the row stage; valid/ready handshakes on both sides.

Parameters:
- W, 12, coefficient width in bits
- N, 8, block dimension (N×N elements, N transfers per block)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_col holds a valid column
- in_ready  out  1  buffer can accept a column this cycle
- in_col  in  N*W  column data; element for row i at bits [i*W +: W]
- out_valid  out  1  out_row holds a valid row
- out_ready  in  1  downstream accepts out_row this cycle
- out_row  out  N*W  row data; element for column j at bits [j*W +: W]
- out_last  out  1  high with out_valid on row N-1 of a block

Behaviour:
- Storage: two banks of N×N×W registers; per-bank full flag; wr_bank, wr_col (0..N-1), rd_bank, rd_row (0..N-1).
- Reset (rst low, async): full flags 0, wr_bank=rd_bank=0, wr_col=rd_row=0; hence in_ready=1, out_valid=0, out_last=0. Storage contents are not reset. out_row is don't-care while out_valid=0.
- in_ready = !full[wr_bank].
  - Registered state only; no combinational path from out_ready.
- Write accept (in_valid && in_ready):
  - element i is stored at bank[wr_bank][row i][col wr_col];
  - wr_col increments.
  - On wr_col==N-1: full[wr_bank] is set, wr_col wraps to 0, wr_bank toggles.
- in_valid while in_ready=0: the column is ignored. The source holds the data.
- out_valid = full[rd_bank].
  - out_row is a combinational mux of bank[rd_bank][row rd_row].
  - out_last = out_valid && rd_row==N-1.
- Read transfer (out_valid && out_ready):
  - rd_row increments.
  - On rd_row==N-1: full[rd_bank] is cleared, rd_row wraps to 0, rd_bank toggles.
- Latency: if the last column of a block is accepted in cycle k, out_valid is 1 in cycle k+1 with row 0.
- Throughput: with in_valid and out_ready held high, one column in and one row out every cycle. in_ready never deasserts.
  - A bank cleared at the end of cycle t is writable in cycle t+1.
- Simultaneous events: completing a write of one bank and completing a read of the other in the same cycle update both flags independently. The write pointer can never target a full bank, so no write/read hazard exists on a bank.
- Both banks full: in_ready=0 until the read side drains rd_bank completely.
- Reset mid-block: the partial block and any full banks are discarded. The first column after reset is column 0 of bank 0.
- Handshake rule: once asserted, out_valid and out_row stay stable until the transfer.

Test Plan:
- Single block, element(r,c)=16*r+c, columns in on cycles 0..7, out_ready=1 → out_valid from cycle 8. Row r = {16r+7,…,16r+0} (MSB→LSB), out_last on row 7 only.
- Three back-to-back blocks, in_valid=out_ready=1 continuously, block b element = 256*b+16*r+c → in_ready stays 1. 24 rows out in order on consecutive cycles; out_last every 8th row.
- out_ready=0 while streaming columns → in_ready=1 for 16 columns, drops on cycle 16. After out_ready rises, in_ready returns the cycle after the 8th row transfer, and the 17th column lands in bank 0.
- Random in_valid/out_ready (≈50% each) over 100 blocks → output equals the transpose of each input block. out_row is stable while out_valid && !out_ready. No block is lost or duplicated.
- rst pulsed low after 5 columns and again while both banks are full → in_ready=1 and out_valid=0 immediately, asynchronously. A fresh block after reset is transposed correctly with no stale rows.
- A write completes bank 1 in the same cycle a read completes bank 0 → next cycle full[0]=0, full[1]=1, out_valid=1 showing bank 1 row 0, in_ready=1.
